shift_wb_ctrl: RTL and testbench

//  Multicycle sequencer for R-type shift instructions (sll, srl, sra, sllv, srlv, srav).

---
 rtl/shift_wb_if.sv | 30 +++
 rtl/shift_wb_ctrl.sv | 147 ++++++++++++++
 tb/tb_shift_wb_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_wb_if.sv
// Handshake and control bundle between the main control unit (master) and the
// shift write-back sequencer (slave).
//   start, funct        : request and instruction funct field, master -> slave
//   busy, done, illegal : sequencer status, slave -> master
//   SHIFT_op, shift_in_sel, shift_n_sel : shift-register controls
//   MEMtoREG_SELETOR, reg_write          : register-file write-back controls
interface shift_wb_if;
  logic       start;
  logic [5:0] funct;
  logic       busy;
  logic       done;
  logic       illegal;
  logic [2:0] SHIFT_op;
  logic       shift_in_sel;
  logic       shift_n_sel;
  logic [3:0] MEMtoREG_SELETOR;
  logic       reg_write;

  modport master (
    output start, funct,
    input  busy, done, illegal, SHIFT_op, shift_in_sel, shift_n_sel,
           MEMtoREG_SELETOR, reg_write
  );

  modport slave (
    input  start, funct,
    output busy, done, illegal, SHIFT_op, shift_in_sel, shift_n_sel,
           MEMtoREG_SELETOR, reg_write
  );
endinterface

// File: rtl/shift_wb_ctrl.sv
// Multicycle sequencer for R-type shifts (sll, srl, sra, sllv, srlv, srav).
// On an accepted start it walks LOAD -> SHIFT -> WAIT (SHIFT_LAT-1 cycles) ->
// WB -> DONE, driving the shift register and then the register-file write-back.
// An illegal funct is answered with a one-cycle done+illegal pulse from IDLE.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : synchronous reset, active-low
//   bus      : shift_wb_if slave modport (start/funct in, status and controls out)
// Parameter:
//   SHIFT_LAT: cycles the shift register needs after a shift command (1..15)
module shift_wb_ctrl #(
  parameter int unsigned SHIFT_LAT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  shift_wb_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_WAIT, S_WB, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SLL  = 3'b010,
    OP_SRL  = 3'b011,
    OP_SRA  = 3'b100
  } shift_op_t;

  localparam logic [3:0] SEL_SHIFT = 4'b1000;
  localparam logic [3:0] WAIT_INIT = 4'(SHIFT_LAT - 1);

  // Legal shift functs are 000xyz with yz != 01; bit 2 marks the variable forms.
  function automatic logic is_legal(input logic [5:0] f);
    case (f)
      6'b000000, 6'b000010, 6'b000011,
      6'b000100, 6'b000110, 6'b000111: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic shift_op_t shift_code(input logic [1:0] k);
    case (k)
      2'b00:   return OP_SLL;
      2'b10:   return OP_SRL;
      2'b11:   return OP_SRA;
      default: return OP_NOP;
    endcase
  endfunction

  state_t     state;
  logic [2:0] kind;      // funct[2:0] of the accepted instruction
  logic [3:0] cnt;
  logic       busy_q, done_q, illegal_q, n_sel_q, rw_q;
  shift_op_t  op_q;
  logic [3:0] sel_q;

  // Outputs are registered alongside the state: each transition loads the
  // values that belong to the state being entered.
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking so all registers update
    // together from pre-edge values; the pulse defaults below are overridden
    // later in the same block, which is well defined for non-blocking writes.
    if (!reset_n) begin
      state     <= S_IDLE;
      kind      <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      op_q      <= OP_NOP;
      n_sel_q   <= 1'b0;
      sel_q     <= '0;
      rw_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      rw_q      <= 1'b0;
      sel_q     <= '0;
      op_q      <= OP_NOP;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (is_legal(bus.funct)) begin
              kind   <= bus.funct[2:0];
              state  <= S_LOAD;
              busy_q <= 1'b1;
              op_q   <= OP_LOAD;
            end else begin
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          state   <= S_SHIFT;
          op_q    <= shift_code(kind[1:0]);
          n_sel_q <= kind[2];
        end
        S_SHIFT: begin
          if (SHIFT_LAT > 1) begin
            cnt   <= WAIT_INIT;
            state <= S_WAIT;
          end else begin
            state   <= S_WB;
            n_sel_q <= 1'b0;
            sel_q   <= SEL_SHIFT;
            rw_q    <= 1'b1;
          end
        end
        S_WAIT: begin
          // Leave when this decrement reaches zero, giving SHIFT_LAT-1 WAIT
          // cycles; cnt is at least 1 on entry so it never wraps.
          if (cnt == 4'd1) begin
            cnt     <= '0;
            state   <= S_WB;
            n_sel_q <= 1'b0;
            sel_q   <= SEL_SHIFT;
            rw_q    <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_WB: begin
          state  <= S_DONE;
          done_q <= 1'b1;
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.illegal          = illegal_q;
  assign bus.SHIFT_op         = op_q;
  assign bus.shift_in_sel     = 1'b0;   // only source today is B (rt)
  assign bus.shift_n_sel      = n_sel_q;
  assign bus.MEMtoREG_SELETOR = sel_q;
  assign bus.reg_write        = rw_q;

endmodule

// File: tb/tb_shift_wb_ctrl.sv
// Directed bench for shift_wb_ctrl with two instances: SHIFT_LAT=1 and 3.
// Output snapshot layout (13 bits):
//   {busy, done, illegal, SHIFT_op[2:0], shift_n_sel, shift_in_sel, SEL[3:0], reg_write}
module tb_shift_wb_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  shift_wb_if if1 ();
  shift_wb_if if3 ();

  shift_wb_ctrl #(.SHIFT_LAT(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  shift_wb_ctrl #(.SHIFT_LAT(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(if3));

  wire [12:0] obs1 = {if1.busy, if1.done, if1.illegal, if1.SHIFT_op, if1.shift_n_sel,
                      if1.shift_in_sel, if1.MEMtoREG_SELETOR, if1.reg_write};
  wire [12:0] obs3 = {if3.busy, if3.done, if3.illegal, if3.SHIFT_op, if3.shift_n_sel,
                      if3.shift_in_sel, if3.MEMtoREG_SELETOR, if3.reg_write};

  localparam logic [12:0] V_IDLE = 13'b0_0_0_000_0_0_0000_0;
  localparam logic [12:0] V_LOAD = 13'b1_0_0_001_0_0_0000_0;
  localparam logic [12:0] V_WB   = 13'b1_0_0_000_0_0_1000_1;
  localparam logic [12:0] V_DONE = 13'b1_1_0_000_0_0_0000_0;
  localparam logic [12:0] V_ILL  = 13'b0_1_1_000_0_0_0000_0;

  int checks = 0;
  int failures = 0;

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if (obs1 !== V_IDLE) begin
      failures++;
      $display("FAIL reset_lat1 got=%b exp=%b", obs1, V_IDLE);
    end
    checks++;
    if (obs3 !== V_IDLE) begin
      failures++;
      $display("FAIL reset_lat3 got=%b exp=%b", obs3, V_IDLE);
    end
    reset_n = 1'b1;
    step();
  endtask

  // srl on the LAT=3 instance, reset asserted while in WAIT.
  task automatic test_reset_mid();
    int pulses;
    if3.start = 1'b1;
    if3.funct = 6'b000010;
    step();
    if3.start = 1'b0;
    step();
    step();
    checks++;
    if (obs3 !== 13'b1_0_0_000_0_0_0000_0) begin
      failures++;
      $display("FAIL reset_mid_wait got=%b exp=%b", obs3, 13'b1_0_0_000_0_0_0000_0);
    end
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs3 !== V_IDLE) begin
        failures++;
        $display("FAIL reset_mid_clear%0d got=%b exp=%b", i, obs3, V_IDLE);
      end
    end
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (if3.done || if3.reg_write) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_pulse got=%0d exp=0", pulses);
    end
  endtask

  // sll on LAT=1: done in the 5th cycle counting the start cycle as the first.
  task automatic test_sll_lat1();
    logic [12:0] exp_v [5];
    exp_v = '{V_LOAD, 13'b1_0_0_010_0_0_0000_0, V_WB, V_DONE, V_IDLE};
    if1.start = 1'b1;
    if1.funct = 6'b000000;
    step();
    if1.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs1 !== exp_v[k]) begin
        failures++;
        $display("FAIL sll_lat1_cyc%0d got=%b exp=%b", k + 2, obs1, exp_v[k]);
      end
      step();
    end
  endtask

  // srav on LAT=3: two WAIT cycles, done in the 7th cycle.
  task automatic test_srav_lat3();
    logic [12:0] exp_v [7];
    exp_v = '{V_LOAD, 13'b1_0_0_100_1_0_0000_0, 13'b1_0_0_000_1_0_0000_0,
              13'b1_0_0_000_1_0_0000_0, V_WB, V_DONE, V_IDLE};
    if3.start = 1'b1;
    if3.funct = 6'b000111;
    step();
    if3.start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (obs3 !== exp_v[k]) begin
        failures++;
        $display("FAIL srav_lat3_cyc%0d got=%b exp=%b", k + 2, obs3, exp_v[k]);
      end
      step();
    end
  endtask

  task automatic test_illegal();
    logic [5:0] bad [4];
    bad = '{6'b100000, 6'b000001, 6'b001000, 6'b111111};
    for (int i = 0; i < 4; i++) begin
      if1.start = 1'b1;
      if1.funct = bad[i];
      step();
      if1.start = 1'b0;
      checks++;
      if (obs1 !== V_ILL) begin
        failures++;
        $display("FAIL illegal_%b_pulse got=%b exp=%b", bad[i], obs1, V_ILL);
      end
      step();
      checks++;
      if (obs1 !== V_IDLE) begin
        failures++;
        $display("FAIL illegal_%b_after got=%b exp=%b", bad[i], obs1, V_IDLE);
      end
    end
  endtask

  // Remaining legal functs: SHIFT-state op code and amount source.
  task automatic test_decode();
    logic [5:0]  fn    [4];
    logic [12:0] exp_v [4];
    fn    = '{6'b000010, 6'b000011, 6'b000100, 6'b000110};
    exp_v = '{13'b1_0_0_011_0_0_0000_0, 13'b1_0_0_100_0_0_0000_0,
              13'b1_0_0_010_1_0_0000_0, 13'b1_0_0_011_1_0_0000_0};
    for (int i = 0; i < 4; i++) begin
      if1.start = 1'b1;
      if1.funct = fn[i];
      step();
      if1.start = 1'b0;
      step();
      checks++;
      if (obs1 !== exp_v[i]) begin
        failures++;
        $display("FAIL decode_%b got=%b exp=%b", fn[i], obs1, exp_v[i]);
      end
      step();
      step();
      step();
    end
  endtask

  // Second start while busy must be dropped.
  task automatic test_busy_ignored();
    int dones;
    int writes;
    dones = 0;
    writes = 0;
    if1.start = 1'b1;
    if1.funct = 6'b000000;
    step();
    if1.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (if1.done) dones++;
      if (if1.reg_write) writes++;
      if (i == 0) begin
        if1.start = 1'b1;
        if1.funct = 6'b000010;
      end
      step();
      if1.start = 1'b0;
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL busy_ignored_done got=%0d exp=1", dones);
    end
    checks++;
    if (writes !== 1) begin
      failures++;
      $display("FAIL busy_ignored_write got=%0d exp=1", writes);
    end
  endtask

  // Start in the IDLE cycle right after done: busy low for that cycle only.
  task automatic test_back_to_back();
    logic [12:0] exp_v [4];
    exp_v = '{V_LOAD, 13'b1_0_0_011_1_0_0000_0, V_WB, V_DONE};
    if1.start = 1'b1;
    if1.funct = 6'b000000;
    step();
    if1.start = 1'b0;
    step();
    step();
    step();
    checks++;
    if (obs1 !== V_DONE) begin
      failures++;
      $display("FAIL b2b_first_done got=%b exp=%b", obs1, V_DONE);
    end
    step();
    checks++;
    if (obs1 !== V_IDLE) begin
      failures++;
      $display("FAIL b2b_gap got=%b exp=%b", obs1, V_IDLE);
    end
    if1.start = 1'b1;
    if1.funct = 6'b000110;
    step();
    if1.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs1 !== exp_v[k]) begin
        failures++;
        $display("FAIL b2b_second_cyc%0d got=%b exp=%b", k + 2, obs1, exp_v[k]);
      end
      step();
    end
  endtask

  initial begin
    if1.start = 1'b0;
    if1.funct = '0;
    if3.start = 1'b0;
    if3.funct = '0;
    test_reset();
    test_reset_mid();
    test_sll_lat1();
    test_srav_lat3();
    test_illegal();
    test_decode();
    test_busy_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
